// File: rtl/vproc_pkg.sv
// Shared types for the vector issue stage: unit selector, operand encodings,
// dispatcher state and the register-group mask helper.
package vproc_pkg;

  typedef enum logic [2:0] {
    UNIT_LSU  = 3'd0,
    UNIT_ALU  = 3'd1,
    UNIT_MUL  = 3'd2,
    UNIT_SLD  = 3'd3,
    UNIT_ELEM = 3'd4,
    UNIT_CFG  = 3'd5
  } op_unit;

  typedef logic [1:0] cfg_emul;

  typedef struct packed {
    logic       vreg;
    logic [4:0] addr;
  } op_regd;

  typedef struct packed {
    logic [2:0] vsew;
    logic [2:0] lmul;
  } cfg_mode;

  typedef struct packed {
    logic [3:0] op;
    cfg_mode    cfg;
  } op_mode;

  typedef enum logic [1:0] {
    DISP_RUN,
    DISP_DRAIN,
    DISP_CFG
  } dispatch_state;

  // Groups are aligned, so members are formed by OR-ing the offset into the base.
  function automatic logic [31:0] vreg_mask(input op_regd r, input cfg_emul emul);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 8; k++) begin
      if (r.vreg && (k < (1 << emul))) begin
        m[r.addr | 5'(k)] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/vproc_dispatch_idtab.sv
// Outstanding-instruction table: busy bit plus write mask per ID, multi-port done clear.
// VPROC_DISPATCH_BYPASS_EN: same-cycle dones are hidden from o_busy_eff and o_pend.
module vproc_dispatch_idtab #(
  parameter int ID_W     = 3,
  parameter int UNIT_CNT = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_alloc,
  input  logic [ID_W-1:0]          i_alloc_id,
  input  logic [31:0]              i_alloc_wmask,
  input  logic [UNIT_CNT-1:0]      i_done_valid,
  input  logic [UNIT_CNT*ID_W-1:0] i_done_id,
  output logic [(1<<ID_W)-1:0]     o_busy,
  output logic [(1<<ID_W)-1:0]     o_busy_eff,
  output logic [(1<<ID_W)-1:0]     o_done_clr,
  output logic [31:0]              o_pend
);

  localparam int DEPTH = 1 << ID_W;

  logic [DEPTH-1:0] r_busy;
  logic [31:0]      r_wmask [DEPTH];
  logic [DEPTH-1:0] w_done_clr;
  logic [DEPTH-1:0] w_busy_next;
  logic [DEPTH-1:0] w_busy_eff;
  logic [31:0]      w_pend;

  always_comb begin
    w_done_clr = '0;
    for (int u = 0; u < UNIT_CNT; u++) begin
      if (i_done_valid[u]) begin
        w_done_clr[i_done_id[u*ID_W +: ID_W]] = 1'b1;
      end
    end
  end

  always_comb begin
    w_busy_next = r_busy & ~w_done_clr;
    if (i_alloc) begin
      w_busy_next[i_alloc_id] = 1'b1;
    end
  end

`ifdef VPROC_DISPATCH_BYPASS_EN
  assign w_busy_eff = r_busy & ~w_done_clr;
`else
  assign w_busy_eff = r_busy;
`endif

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_busy_eff[i]) begin
        w_pend = w_pend | r_wmask[i];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_wmask[i] <= '0;
      end
    end else begin
      r_busy <= w_busy_next;
      if (i_alloc) begin
        r_wmask[i_alloc_id] <= i_alloc_wmask;
      end
    end
  end

  assign o_busy     = r_busy;
  assign o_busy_eff = w_busy_eff;
  assign o_done_clr = w_done_clr;
  assign o_pend     = w_pend;

endmodule

// File: rtl/vproc_dispatcher.sv
// Issue-stage dispatcher: RAW/WAW hazard stall, in-order ID allocation, CFG drain.
// Optional VPROC_DISPATCH_BYPASS_EN enables same-cycle done bypass inside the ID table.
module vproc_dispatcher
  import vproc_pkg::*;
#(
  parameter int ID_W     = 3,
  parameter int UNIT_CNT = 5
) (
  input  logic                     clk_i,
  input  logic                     async_rst_ni,
  input  logic                     instr_valid_i,
  output logic                     instr_ready_o,
  input  op_unit                   instr_unit_i,
  input  op_mode                   instr_mode_i,
  input  cfg_emul                  instr_emul_i,
  input  op_regd                   instr_vs1_i,
  input  op_regd                   instr_vs2_i,
  input  op_regd                   instr_vd_i,
  output logic [UNIT_CNT-1:0]      disp_valid_o,
  input  logic [UNIT_CNT-1:0]      disp_ready_i,
  output logic [ID_W-1:0]          disp_id_o,
  output op_mode                   disp_mode_o,
  input  logic [UNIT_CNT-1:0]      done_valid_i,
  input  logic [UNIT_CNT*ID_W-1:0] done_id_i,
  output logic                     cfg_valid_o,
  output logic                     busy_o
);

  localparam int DEPTH = 1 << ID_W;

  dispatch_state      r_state;
  dispatch_state      w_state_next;
  logic [ID_W-1:0]    r_next_id;
  logic [31:0]        w_rmask;
  logic [31:0]        w_wmask;
  logic [31:0]        w_pend;
  logic [DEPTH-1:0]   w_busy;
  logic [DEPTH-1:0]   w_busy_eff;
  logic [DEPTH-1:0]   w_done_clr;
  logic [UNIT_CNT-1:0] w_unit_oh;
  logic               w_is_cfg;
  logic               w_hazard;
  logic               w_ok;
  logic               w_accept;
  logic               w_drained;

  vproc_dispatch_idtab #(
    .ID_W     (ID_W),
    .UNIT_CNT (UNIT_CNT)
  ) u_idtab (
    .i_clk         (clk_i),
    .i_rst_n       (async_rst_ni),
    .i_alloc       (w_accept),
    .i_alloc_id    (r_next_id),
    .i_alloc_wmask (w_wmask),
    .i_done_valid  (done_valid_i),
    .i_done_id     (done_id_i),
    .o_busy        (w_busy),
    .o_busy_eff    (w_busy_eff),
    .o_done_clr    (w_done_clr),
    .o_pend        (w_pend)
  );

  assign w_rmask  = vreg_mask(instr_vs1_i, instr_emul_i) | vreg_mask(instr_vs2_i, instr_emul_i);
  assign w_wmask  = vreg_mask(instr_vd_i, instr_emul_i);
  assign w_is_cfg = (instr_unit_i == UNIT_CFG);
  assign w_hazard = |((w_rmask | w_wmask) & w_pend);
  assign w_ok     = instr_valid_i & ~w_hazard & ~w_busy_eff[r_next_id];
  assign w_accept = (r_state == DISP_RUN) & ~w_is_cfg & w_ok & |(w_unit_oh & disp_ready_i);
  // A done landing this cycle already counts as drained, so the strobe follows the last done by one cycle.
  assign w_drained = ~|(w_busy & ~w_done_clr);

  always_comb begin
    w_unit_oh = '0;
    for (int u = 0; u < UNIT_CNT; u++) begin
      w_unit_oh[u] = (int'(instr_unit_i) == u);
    end
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      r_state   <= DISP_RUN;
      r_next_id <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_next_id <= r_next_id + ID_W'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      DISP_RUN:   if (instr_valid_i && w_is_cfg) w_state_next = DISP_DRAIN;
      DISP_DRAIN: if (w_drained) w_state_next = DISP_CFG;
      DISP_CFG:   w_state_next = DISP_RUN;
      default:    w_state_next = DISP_RUN;
    endcase
  end

  always_comb begin
    instr_ready_o = 1'b0;
    disp_valid_o  = '0;
    cfg_valid_o   = 1'b0;
    case (r_state)
      DISP_RUN: begin
        if (!w_is_cfg) begin
          disp_valid_o  = w_ok ? w_unit_oh : '0;
          instr_ready_o = w_accept;
        end
      end
      DISP_CFG: begin
        cfg_valid_o   = 1'b1;
        instr_ready_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign disp_id_o   = r_next_id;
  assign disp_mode_o = instr_mode_i;
  assign busy_o      = |w_busy;

endmodule

// File: tb/tb_vproc_dispatcher.sv
// Scoreboard bench for vproc_dispatcher; honours VPROC_DISPATCH_BYPASS_EN for done-to-issue timing.
module tb_vproc_dispatcher;
  import vproc_pkg::*;

`ifdef VPROC_DISPATCH_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  localparam op_regd NONE = '{vreg: 1'b0, addr: 5'd0};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  op_unit      unit;
  op_mode      mode;
  cfg_emul     emul;
  op_regd      vs1, vs2, vd;
  logic [4:0]  disp_valid;
  logic [4:0]  disp_ready;
  logic [2:0]  disp_id;
  op_mode      disp_mode;
  logic [4:0]  done_valid;
  logic [14:0] done_id;
  logic        cfg_valid;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int nid   = 0;

  typedef struct {
    logic [4:0] oh;
    logic [2:0] id;
    op_mode     mode;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  vproc_dispatcher #(.ID_W(3), .UNIT_CNT(5)) dut (
    .clk_i         (clk),
    .async_rst_ni  (rst_n),
    .instr_valid_i (instr_valid),
    .instr_ready_o (instr_ready),
    .instr_unit_i  (unit),
    .instr_mode_i  (mode),
    .instr_emul_i  (emul),
    .instr_vs1_i   (vs1),
    .instr_vs2_i   (vs2),
    .instr_vd_i    (vd),
    .disp_valid_o  (disp_valid),
    .disp_ready_i  (disp_ready),
    .disp_id_o     (disp_id),
    .disp_mode_o   (disp_mode),
    .done_valid_i  (done_valid),
    .done_id_i     (done_id),
    .cfg_valid_o   (cfg_valid),
    .busy_o        (busy)
  );

  // Scoreboard: every dispatch handshake must match the oldest expected dispatch.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready && unit != UNIT_CFG) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL sb_unexpected: accept id=%0d valid=%b, want no accept", disp_id, disp_valid);
      end else begin
        exp_t e;
        e = sb.pop_front();
        total += 3;
        if (disp_valid !== e.oh) begin bad++; $display("[TB] FAIL sb_valid: got %b want %b", disp_valid, e.oh); end
        if (disp_id !== e.id) begin bad++; $display("[TB] FAIL sb_id: got %0d want %0d", disp_id, e.id); end
        if (disp_mode !== e.mode) begin bad++; $display("[TB] FAIL sb_mode: got %h want %h", disp_mode, e.mode); end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running, want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic op_regd vr(input int a);
    return '{vreg: 1'b1, addr: a[4:0]};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive(input op_unit u, input op_regd d, input op_regd s1, input op_regd s2, input cfg_emul e);
    instr_valid = 1'b1; unit = u; vd = d; vs1 = s1; vs2 = s2; emul = e;
    mode = op_mode'(10'($urandom));
  endtask

  task automatic push_exp(input op_unit u);
    exp_t e;
    e.oh = '0;
    e.oh[int'(u)] = 1'b1;
    e.id = nid[2:0];
    e.mode = mode;
    sb.push_back(e);
    nid = (nid + 1) % 8;
  endtask

  task automatic pulse_done(input int u, input int id);
    done_valid = '0;
    done_valid[u] = 1'b1;
    done_id[u*3 +: 3] = id[2:0];
    step();
    done_valid = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; instr_valid = 1'b0; disp_ready = '1; done_valid = '0; done_id = '0;
    unit = UNIT_ALU; mode = '0; emul = '0; vs1 = NONE; vs2 = NONE; vd = NONE;
    #12;
    total += 5;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    if (disp_valid !== 5'b0) begin bad++; $display("[TB] FAIL reset_disp_valid: got %b want 0", disp_valid); end
    if (cfg_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_cfg: got %b want 0", cfg_valid); end
    if (disp_id !== 3'd0) begin bad++; $display("[TB] FAIL reset_id: got %0d want 0", disp_id); end
    if (instr_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready: got %b want 0", instr_ready); end
    @(posedge clk); #3 rst_n = 1'b1;
    step();
  endtask

  task automatic test_independent();
    drive(UNIT_ALU, vr(1), vr(8), vr(9), 2'd0); push_exp(UNIT_ALU);
    @(negedge clk); total++;
    if (instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL indep_alu: ready=%b want 1", instr_ready); end
    step();
    drive(UNIT_MUL, vr(2), vr(8), vr(9), 2'd0); push_exp(UNIT_MUL);
    @(negedge clk); total++;
    if (instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL indep_mul: ready=%b want 1", instr_ready); end
    step();
    instr_valid = 1'b0;
    @(negedge clk); total++;
    if (busy !== 1'b1) begin bad++; $display("[TB] FAIL indep_busy: got %b want 1", busy); end
    step();
    done_valid = 5'b00110; done_id = '0; done_id[5:3] = 3'd0; done_id[8:6] = 3'd1;
    step();
    done_valid = '0;
    @(negedge clk); total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL indep_clear: busy=%b want 0", busy); end
    step();
  endtask

  task automatic test_raw();
    logic got0;
    drive(UNIT_ALU, vr(4), NONE, NONE, 2'd1); push_exp(UNIT_ALU);
    @(negedge clk); total++;
    if (instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL raw_producer: ready=%b want 1", instr_ready); end
    step();
    drive(UNIT_MUL, vr(20), NONE, vr(5), 2'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); total++;
      if (instr_ready !== 1'b0 || disp_valid !== 5'b0) begin
        bad++; $display("[TB] FAIL raw_stall: ready=%b valid=%b want 0/00000", instr_ready, disp_valid);
      end
      step();
    end
    push_exp(UNIT_MUL);
    done_valid[1] = 1'b1; done_id[5:3] = 3'd2;
    @(negedge clk); total++; got0 = instr_ready;
    if (got0 !== BYP) begin bad++; $display("[TB] FAIL raw_done_cycle: ready=%b want %b", got0, BYP); end
    step();
    done_valid = '0;
    if (got0 !== 1'b1) begin
      @(negedge clk); total++;
      if (instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL raw_after_done: ready=%b want 1", instr_ready); end
      step();
    end
    instr_valid = 1'b0;
    pulse_done(2, 3);
    @(negedge clk); total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL raw_clear: busy=%b want 0", busy); end
    step();
  endtask

  task automatic test_waw();
    logic got0;
    drive(UNIT_LSU, vr(8), NONE, NONE, 2'd0); push_exp(UNIT_LSU);
    @(negedge clk); total++;
    if (instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL waw_lsu: ready=%b want 1", instr_ready); end
    step();
    drive(UNIT_SLD, vr(12), NONE, NONE, 2'd0); push_exp(UNIT_SLD);
    @(negedge clk); total++;
    if (instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL waw_sld: ready=%b want 1", instr_ready); end
    step();
    drive(UNIT_LSU, vr(8), NONE, NONE, 2'd0);
    @(negedge clk); total++;
    if (instr_ready !== 1'b0) begin bad++; $display("[TB] FAIL waw_stall: ready=%b want 0", instr_ready); end
    step();
    push_exp(UNIT_LSU);
    done_valid = 5'b01001; done_id[2:0] = 3'd4; done_id[11:9] = 3'd5;
    @(negedge clk); total++; got0 = instr_ready;
    if (got0 !== BYP) begin bad++; $display("[TB] FAIL waw_done_cycle: ready=%b want %b", got0, BYP); end
    step();
    done_valid = '0;
    if (got0 !== 1'b1) begin
      @(negedge clk); total++;
      if (instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL waw_after_done: ready=%b want 1", instr_ready); end
      step();
    end
    drive(UNIT_SLD, vr(12), NONE, NONE, 2'd0); push_exp(UNIT_SLD);
    @(negedge clk); total++;
    if (instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL waw_sld_reissue: ready=%b want 1", instr_ready); end
    step();
    instr_valid = 1'b0;
    done_valid = 5'b01001; done_id[2:0] = 3'd6; done_id[11:9] = 3'd7;
    step();
    done_valid = '0;
    @(negedge clk); total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL waw_clear: busy=%b want 0", busy); end
    step();
  endtask

  task automatic test_exhaust();
    logic got0;
    for (int i = 0; i < 8; i++) begin
      drive(UNIT_ALU, NONE, NONE, NONE, 2'd0); push_exp(UNIT_ALU);
      @(negedge clk); total++;
      if (instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL exh_fill%0d: ready=%b want 1", i, instr_ready); end
      step();
    end
    drive(UNIT_ALU, NONE, NONE, NONE, 2'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); total++;
      if (instr_ready !== 1'b0 || disp_valid !== 5'b0) begin
        bad++; $display("[TB] FAIL exh_full: ready=%b valid=%b want 0/00000", instr_ready, disp_valid);
      end
      step();
    end
    push_exp(UNIT_ALU);
    done_valid[1] = 1'b1; done_id[5:3] = 3'd0;
    @(negedge clk); total++; got0 = instr_ready;
    if (got0 !== BYP) begin bad++; $display("[TB] FAIL exh_done_cycle: ready=%b want %b", got0, BYP); end
    step();
    done_valid = '0;
    if (got0 !== 1'b1) begin
      @(negedge clk); total++;
      if (instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL exh_after_done: ready=%b want 1", instr_ready); end
      step();
    end
    instr_valid = 1'b0;
    for (int i = 1; i < 8; i++) pulse_done(1, i);
    pulse_done(1, 0);
    @(negedge clk); total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL exh_clear: busy=%b want 0", busy); end
    step();
  endtask

  task automatic test_cfg();
    drive(UNIT_ALU, vr(1), NONE, NONE, 2'd0); push_exp(UNIT_ALU);
    @(negedge clk); total++;
    if (instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL cfg_pre_alu: ready=%b want 1", instr_ready); end
    step();
    drive(UNIT_MUL, vr(2), NONE, NONE, 2'd0); push_exp(UNIT_MUL);
    @(negedge clk); total++;
    if (instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL cfg_pre_mul: ready=%b want 1", instr_ready); end
    step();
    drive(UNIT_CFG, NONE, NONE, NONE, 2'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); total++;
      if (cfg_valid !== 1'b0 || disp_valid !== 5'b0 || instr_ready !== 1'b0) begin
        bad++; $display("[TB] FAIL cfg_drain: cfg=%b valid=%b ready=%b want 0/00000/0", cfg_valid, disp_valid, instr_ready);
      end
      step();
    end
    done_valid[1] = 1'b1; done_id[5:3] = 3'd1;
    @(negedge clk); total++;
    if (cfg_valid !== 1'b0) begin bad++; $display("[TB] FAIL cfg_first_done: cfg=%b want 0", cfg_valid); end
    step();
    done_valid = '0;
    done_valid[2] = 1'b1; done_id[8:6] = 3'd2;
    @(negedge clk); total++;
    if (cfg_valid !== 1'b0) begin bad++; $display("[TB] FAIL cfg_last_done: cfg=%b want 0", cfg_valid); end
    step();
    done_valid = '0;
    @(negedge clk); total += 3;
    if (cfg_valid !== 1'b1) begin bad++; $display("[TB] FAIL cfg_strobe: cfg=%b want 1", cfg_valid); end
    if (instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL cfg_consume: ready=%b want 1", instr_ready); end
    if (disp_mode.cfg !== mode.cfg) begin bad++; $display("[TB] FAIL cfg_mode: got %h want %h", disp_mode.cfg, mode.cfg); end
    step();
    instr_valid = 1'b0;
    @(negedge clk); total += 2;
    if (cfg_valid !== 1'b0) begin bad++; $display("[TB] FAIL cfg_one_shot: cfg=%b want 0", cfg_valid); end
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL cfg_busy: busy=%b want 0", busy); end
    step();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(UNIT_ALU, vr(10 + i), NONE, NONE, 2'd0); push_exp(UNIT_ALU);
      @(negedge clk); total++;
      if (instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_fill%0d: ready=%b want 1", i, instr_ready); end
      step();
    end
    drive(UNIT_MUL, vr(20), vr(10), NONE, 2'd0);
    @(negedge clk); total++;
    if (instr_ready !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_stall: ready=%b want 0", instr_ready); end
    step();
    rst_n = 1'b0;
    #1; total += 2;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_busy: busy=%b want 0", busy); end
    if (disp_id !== 3'd0) begin bad++; $display("[TB] FAIL rstmid_id: got %0d want 0", disp_id); end
    #1 rst_n = 1'b1;
    nid = 0;
    push_exp(UNIT_MUL);
    @(negedge clk); total++;
    if (instr_ready !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_first: ready=%b want 1", instr_ready); end
    step();
    instr_valid = 1'b0;
    pulse_done(2, 0);
    @(negedge clk); total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_clear: busy=%b want 0", busy); end
    step();
  endtask

  initial begin
    test_reset();
    test_independent();
    test_raw();
    test_waw();
    test_exhaust();
    test_cfg();
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin bad++; $display("[TB] FAIL sb_drain: %0d pending, want 0", sb.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
